// File: rtl/seg7_display_ctrl_if.sv
// Register bus between the CPU and the seven-segment scheduler.
// Bus semantics: there is no valid/ready pair. A write is one cycle with
// we=1; addr/wdata are sampled on that rising edge and the write always
// completes. Reads need no strobe: rdata shows, one edge later, the
// register selected by addr in the previous cycle.
interface seg7_display_ctrl_if;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg7_display_ctrl.sv
// Scheduler for the 4-digit seven-segment driver: digit scan index, blink
// phase, and a frame-synchronous shadow of the CPU-written display word.
module seg7_display_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_display_ctrl_if.slave    bus,
  output logic [1:0]            scan_o,
  output logic                  flash_o,
  output logic [31:0]           data_o
);
  localparam int CW  = $clog2(SCAN_DIV);
  localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FW8 = (FW < 8) ? FW : 8;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    scan_q,    scan_d;
  logic [FW-1:0] frame_q,   frame_d;
  logic          flash_q,   flash_d;
  logic [1:0]    ctrl_q,    ctrl_d;     // [0] scan_en, [1] blink_en
  logic [31:0]   pending_q, pending_d;
  logic [31:0]   data_q,    data_d;
  logic [31:0]   rdata_q,   rdata_d;

  logic       wr_data, wr_ctrl;
  logic       scan_en, blink_en;
  logic       tick, boundary, frame_wrap;
  logic [7:0] frame8;

  assign wr_data    = bus.we && (bus.addr == 2'd0);
  assign wr_ctrl    = bus.we && (bus.addr == 2'd1);
  assign scan_en    = ctrl_q[0];
  assign blink_en   = ctrl_q[1];
  assign tick       = scan_en && (cnt_q == CNT_MAX);
  assign boundary   = tick && (scan_q == 2'd3);
  assign frame_wrap = boundary && (frame_q == FRAME_MAX);
  // Status shows only the low 8 frame-counter bits, zero-extended if narrower.
  assign frame8     = 8'(frame_q[FW8-1:0]);

  // Next-state logic for prescaler, scan, blink, registers and read mux.
  always_comb begin
    cnt_d     = cnt_q;
    scan_d    = scan_q;
    frame_d   = frame_q;
    flash_d   = flash_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    data_d    = data_q;
    rdata_d   = 32'd0;

    if (scan_en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
    if (tick) begin
      scan_d = scan_q + 2'd1;
    end
    if (boundary) begin
      frame_d = frame_wrap ? '0 : frame_q + FW'(1);
    end

    if (frame_wrap) begin
      flash_d = blink_en ? ~flash_q : 1'b0;
    end
    // Clearing blink_en kills the flash phase immediately, not at the next wrap.
    if (wr_ctrl && !bus.wdata[1]) begin
      flash_d = 1'b0;
    end

    if (wr_ctrl) begin
      ctrl_d = bus.wdata[1:0];
    end
    if (wr_data) begin
      pending_d = bus.wdata;
    end

    // Driver word changes only between frames; a write landing on the
    // boundary goes straight through so it is not delayed a whole frame.
    // With scanning stopped there is no boundary, so just track pending.
    if (boundary) begin
      data_d = wr_data ? bus.wdata : pending_q;
    end else if (!scan_en) begin
      data_d = pending_q;
    end

    case (bus.addr)
      2'd0:    rdata_d = pending_q;
      2'd1:    rdata_d = {30'd0, ctrl_q};
      2'd2:    rdata_d = {16'd0, frame8, 5'd0, flash_q, scan_q};
      default: rdata_d = 32'd0;
    endcase
  end

  // State registers; reset wins over any same-cycle update or bus write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      scan_q    <= 2'd0;
      frame_q   <= '0;
      flash_q   <= 1'b0;
      ctrl_q    <= 2'b01;
      pending_q <= 32'd0;
      data_q    <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      scan_q    <= scan_d;
      frame_q   <= frame_d;
      flash_q   <= flash_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
    end
  end

  assign scan_o    = scan_q;
  assign flash_o   = flash_q;
  assign data_o    = data_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with SCAN_DIV=4, BLINK_FRAMES=2
// (tick every 4 clk, 16 clk per frame, flash half-period 32 clk).
module tb_seg7_display_ctrl;
  logic        clk;
  logic        rst;
  logic [1:0]  scan_o;
  logic        flash_o;
  logic [31:0] data_o;
  int          pass_cnt;
  int          total_cnt;

  seg7_display_ctrl_if bus ();

  seg7_display_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .scan_o  (scan_o),
    .flash_o (flash_o),
    .data_o  (data_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges; inputs change and outputs are sampled 1ns after.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1ns after the last reset edge: prescaler=0, scan=0.
  task automatic do_reset();
    rst       = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'd0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (scan_o !== 2'd0) $display("FAIL reset_scan: got %0d want 0", scan_o); else pass_cnt++;
    total_cnt++; if (flash_o !== 1'b0) $display("FAIL reset_flash: got %0b want 0", flash_o); else pass_cnt++;
    total_cnt++; if (data_o !== 32'd0) $display("FAIL reset_data: got %h want 0", data_o); else pass_cnt++;
    total_cnt++; if (bus.rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", bus.rdata); else pass_cnt++;
    bus.addr = 2'd1;
    step(1);
    total_cnt++; if (bus.rdata !== 32'h1) $display("FAIL reset_ctrl: got %h want 00000001", bus.rdata); else pass_cnt++;
    // Writes to STATUS and reserved are ignored; reserved reads 0.
    bus.we = 1'b1; bus.addr = 2'd3; bus.wdata = 32'hFFFF_FFFF;
    step(1);
    bus.addr = 2'd2;
    step(1);
    bus.we = 1'b0; bus.addr = 2'd3;
    step(1);
    total_cnt++; if (bus.rdata !== 32'd0) $display("FAIL reserved_read: got %h want 0", bus.rdata); else pass_cnt++;
    bus.addr = 2'd1;
    step(1);
    total_cnt++; if (bus.rdata !== 32'h1) $display("FAIL ctrl_after_ro_writes: got %h want 00000001", bus.rdata); else pass_cnt++;
  endtask

  task automatic test_scan();
    int exp_scan;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1);
      exp_scan = (i / 4) % 4;
      total_cnt++; if (scan_o !== 2'(exp_scan)) $display("FAIL scan_seq c%0d: got %0d want %0d", i, scan_o, exp_scan); else pass_cnt++;
      total_cnt++; if (flash_o !== 1'b0) $display("FAIL scan_flash c%0d: got %0b want 0", i, flash_o); else pass_cnt++;
    end
    // After the first frame: frame=1, scan=0, flash=0.
    bus.addr = 2'd2;
    step(1);
    total_cnt++; if (bus.rdata !== 32'h0000_0100) $display("FAIL status_frame1: got %h want 00000100", bus.rdata); else pass_cnt++;
  endtask

  task automatic test_data_shadow();
    do_reset();
    step(4);
    total_cnt++; if (scan_o !== 2'd1) $display("FAIL shadow_scan1: got %0d want 1", scan_o); else pass_cnt++;
    bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = 32'h1234_5678;
    step(1);
    bus.we = 1'b0;
    total_cnt++; if (data_o !== 32'd0) $display("FAIL shadow_hold0: got %h want 0", data_o); else pass_cnt++;
    step(1);
    total_cnt++; if (bus.rdata !== 32'h1234_5678) $display("FAIL shadow_read: got %h want 12345678", bus.rdata); else pass_cnt++;
    step(9);
    total_cnt++; if (data_o !== 32'd0) $display("FAIL shadow_hold15: got %h want 0", data_o); else pass_cnt++;
    step(1);
    total_cnt++; if (data_o !== 32'h1234_5678) $display("FAIL shadow_boundary: got %h want 12345678", data_o); else pass_cnt++;
  endtask

  task automatic test_blink();
    do_reset();
    bus.we = 1'b1; bus.addr = 2'd1; bus.wdata = 32'h3;
    step(1);
    bus.we = 1'b0;
    step(30);
    total_cnt++; if (flash_o !== 1'b0) $display("FAIL blink_c31: got %0b want 0", flash_o); else pass_cnt++;
    step(1);
    total_cnt++; if (flash_o !== 1'b1) $display("FAIL blink_c32: got %0b want 1", flash_o); else pass_cnt++;
    step(31);
    total_cnt++; if (flash_o !== 1'b1) $display("FAIL blink_c63: got %0b want 1", flash_o); else pass_cnt++;
    step(1);
    total_cnt++; if (flash_o !== 1'b0) $display("FAIL blink_c64: got %0b want 0", flash_o); else pass_cnt++;
    step(32);
    total_cnt++; if (flash_o !== 1'b1) $display("FAIL blink_c96: got %0b want 1", flash_o); else pass_cnt++;
    // Clear blink_en while reading STATUS (frame 0, flash 1, scan 0).
    bus.we = 1'b1; bus.addr = 2'd1; bus.wdata = 32'h1;
    step(1);
    bus.we = 1'b0; bus.addr = 2'd2;
    total_cnt++; if (flash_o !== 1'b0) $display("FAIL blink_off: got %0b want 0", flash_o); else pass_cnt++;
    step(1);
    total_cnt++; if (bus.rdata !== 32'h0000_0000) $display("FAIL status_blink_off: got %h want 00000000", bus.rdata); else pass_cnt++;
  endtask

  task automatic test_freeze();
    do_reset();
    step(8);
    total_cnt++; if (scan_o !== 2'd2) $display("FAIL freeze_scan2: got %0d want 2", scan_o); else pass_cnt++;
    // Upper CTRL bits are write-ignored; this clears scan_en and blink_en.
    bus.we = 1'b1; bus.addr = 2'd1; bus.wdata = 32'hFFFF_FFF0;
    step(1);
    bus.we = 1'b0;
    step(1);
    total_cnt++; if (bus.rdata !== 32'd0) $display("FAIL freeze_ctrl_read: got %h want 0", bus.rdata); else pass_cnt++;
    step(99);
    total_cnt++; if (scan_o !== 2'd2) $display("FAIL freeze_hold: got %0d want 2", scan_o); else pass_cnt++;
    bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = 32'hCAFE_F00D;
    step(1);
    bus.we = 1'b0;
    step(1);
    total_cnt++; if (data_o !== 32'hCAFE_F00D) $display("FAIL freeze_data: got %h want cafef00d", data_o); else pass_cnt++;
    total_cnt++; if (scan_o !== 2'd2) $display("FAIL freeze_scan_end: got %0d want 2", scan_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(15);
    total_cnt++; if (scan_o !== 2'd3) $display("FAIL bypass_scan3: got %0d want 3", scan_o); else pass_cnt++;
    bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = 32'hAAAA_0000;
    step(1);
    bus.we = 1'b0;
    total_cnt++; if (data_o !== 32'hAAAA_0000) $display("FAIL bypass_data: got %h want aaaa0000", data_o); else pass_cnt++;
    total_cnt++; if (scan_o !== 2'd0) $display("FAIL bypass_scan0: got %0d want 0", scan_o); else pass_cnt++;
    step(1);
    total_cnt++; if (bus.rdata !== 32'hAAAA_0000) $display("FAIL bypass_pending: got %h want aaaa0000", bus.rdata); else pass_cnt++;
    step(16);
    total_cnt++; if (data_o !== 32'hAAAA_0000) $display("FAIL bypass_next_frame: got %h want aaaa0000", data_o); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.we = 1'b1; bus.addr = 2'd1; bus.wdata = 32'h3;
    step(1);
    bus.addr = 2'd0; bus.wdata = 32'h0000_0055;
    step(1);
    bus.we = 1'b0;
    step(30);
    total_cnt++; if (flash_o !== 1'b1) $display("FAIL rstmid_flash_pre: got %0b want 1", flash_o); else pass_cnt++;
    step(12);
    total_cnt++; if (scan_o !== 2'd3) $display("FAIL rstmid_scan_pre: got %0d want 3", scan_o); else pass_cnt++;
    total_cnt++; if (data_o !== 32'h0000_0055) $display("FAIL rstmid_data_pre: got %h want 00000055", data_o); else pass_cnt++;
    rst = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = 32'hFFFF_FFFF;
    step(1);
    rst = 1'b0; bus.we = 1'b0; bus.addr = 2'd1;
    total_cnt++; if (scan_o !== 2'd0) $display("FAIL rstmid_scan: got %0d want 0", scan_o); else pass_cnt++;
    total_cnt++; if (flash_o !== 1'b0) $display("FAIL rstmid_flash: got %0b want 0", flash_o); else pass_cnt++;
    total_cnt++; if (data_o !== 32'd0) $display("FAIL rstmid_data: got %h want 0", data_o); else pass_cnt++;
    step(1);
    bus.addr = 2'd0;
    total_cnt++; if (bus.rdata !== 32'h1) $display("FAIL rstmid_ctrl: got %h want 00000001", bus.rdata); else pass_cnt++;
    step(1);
    total_cnt++; if (bus.rdata !== 32'd0) $display("FAIL rstmid_pending: got %h want 0", bus.rdata); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'd0;
    test_reset();
    test_scan();
    test_data_shadow();
    test_blink();
    test_freeze();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
